// File: rtl/tm1638_led_tx.sv
// -----------------------------------------------------------------------------
// tm1638_led_tx
// Serialises an 8-bit LED pattern onto the TM1638 three-wire bus (STB/CLK/DIO)
// so that bit i of the pattern lights discrete LED i on the TM1638 board.
// A complete transfer is sent after reset and whenever the pattern changes.
// The bus is write-only; no key scan is performed.
//
// Transfer layout (one STB-low window per frame, bytes LSB first):
//   F0      : 0x44                       (write data, fixed address)
//   LED i   : 0xC1+2i, {7'b0, snap[i]}   (i = 0..7)
//   last    : 0x88 | BRIGHTNESS          (display on, brightness)
// Optional build macro TM_BLANK_DIGITS_EN inserts eight frames
// (0xC0+2j, 0x00) between F0 and the LED frames to clear the digit RAM.
//
// Parameters:
//   CLK_DIV    - system clocks per tick (one serial half-period), >= 2
//   BRIGHTNESS - 3-bit brightness for the display-control command
//
// Ports:
//   clk    in   system clock
//   rs     in   synchronous active-high reset
//   led    in   [7:0] LED pattern
//   tm_stb out  TM1638 strobe, active-low
//   tm_clk out  TM1638 serial clock, idles high
//   tm_dio out  TM1638 data, valid on rising tm_clk
//   busy   out  high while a transfer is in progress
// -----------------------------------------------------------------------------
module tm1638_led_tx #(
    parameter int         CLK_DIV    = 50,
    parameter logic [2:0] BRIGHTNESS = 3'd7
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [7:0] led,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

`ifdef TM_BLANK_DIGITS_EN
    localparam logic [4:0] LED_BASE   = 5'd9;
    localparam logic [4:0] LAST_FRAME = 5'd17;
`else
    localparam logic [4:0] LED_BASE   = 5'd1;
    localparam logic [4:0] LAST_FRAME = 5'd9;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        STB_SETUP,
        BIT_LOW,
        BIT_HIGH,
        STB_HOLD,
        GAP
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic               tick;
    logic               init_pending;
    logic [7:0]         snap;
    logic [7:0]         last_sent;
    logic [4:0]         frame;
    logic               byte_idx;
    logic [2:0]         bit_idx;
    logic               two_byte;
    logic [7:0]         cur_byte;
    logic [7:0]         second_byte;

    // Byte b of frame f, built from the captured snapshot s.
    function automatic logic [7:0] frame_byte(input logic [4:0] f,
                                              input logic       b,
                                              input logic [7:0] s);
        logic [2:0] idx;
        frame_byte = 8'h00;
        idx        = 3'd0;
        if (f == 5'd0) begin
            frame_byte = 8'h44;
        end else if (f == LAST_FRAME) begin
            frame_byte = 8'h88 | {5'b0, BRIGHTNESS};
`ifdef TM_BLANK_DIGITS_EN
        end else if (f < LED_BASE) begin
            idx        = 3'(f - 5'd1);
            frame_byte = b ? 8'h00 : (8'hC0 + {4'b0, idx, 1'b0});
`endif
        end else begin
            idx        = 3'(f - LED_BASE);
            frame_byte = b ? {7'b0, s[idx]} : (8'hC1 + {4'b0, idx, 1'b0});
        end
    endfunction

    assign tick        = (div == DIV_W'(CLK_DIV - 1));
    assign two_byte    = (frame != 5'd0) && (frame != LAST_FRAME);
    assign cur_byte    = frame_byte(frame, byte_idx, snap);
    // Lookahead for the first bit of the second byte, driven as the first
    // byte finishes so the frame needs no STB release between bytes.
    assign second_byte = frame_byte(frame, 1'b1, snap);

    always_ff @(posedge clk) begin
        if (rs) begin
            state        <= IDLE;
            tm_stb       <= 1'b1;
            tm_clk       <= 1'b1;
            tm_dio       <= 1'b1;
            busy         <= 1'b0;
            div          <= '0;
            init_pending <= 1'b1;
            frame        <= 5'd0;
            byte_idx     <= 1'b0;
            bit_idx      <= 3'd0;
        end else begin
            // Divider restarts from zero at the start of every transfer so
            // each state lasts exactly CLK_DIV cycles.
            if (state == IDLE || state == START || tick)
                div <= '0;
            else
                div <= div + 1'b1;

            case (state)
                IDLE: begin
                    if (init_pending || (led != last_sent)) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    snap     <= led;
                    frame    <= 5'd0;
                    byte_idx <= 1'b0;
                    bit_idx  <= 3'd0;
                    tm_stb   <= 1'b0;
                    state    <= STB_SETUP;
                end
                STB_SETUP: begin
                    if (tick) begin
                        tm_clk <= 1'b0;
                        tm_dio <= cur_byte[0];
                        state  <= BIT_LOW;
                    end
                end
                BIT_LOW: begin
                    if (tick) begin
                        tm_clk <= 1'b1;
                        state  <= BIT_HIGH;
                    end
                end
                BIT_HIGH: begin
                    if (tick) begin
                        if (bit_idx != 3'd7) begin
                            bit_idx <= bit_idx + 3'd1;
                            tm_clk  <= 1'b0;
                            tm_dio  <= cur_byte[bit_idx + 3'd1];
                            state   <= BIT_LOW;
                        end else if (two_byte && !byte_idx) begin
                            byte_idx <= 1'b1;
                            bit_idx  <= 3'd0;
                            tm_clk   <= 1'b0;
                            tm_dio   <= second_byte[0];
                            state    <= BIT_LOW;
                        end else begin
                            tm_stb <= 1'b1;
                            state  <= STB_HOLD;
                        end
                    end
                end
                STB_HOLD: begin
                    if (tick)
                        state <= GAP;
                end
                GAP: begin
                    if (tick) begin
                        if (frame == LAST_FRAME) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            tm_dio       <= 1'b1;
                            last_sent    <= snap;
                            init_pending <= 1'b0;
                        end else begin
                            frame    <= frame + 5'd1;
                            byte_idx <= 1'b0;
                            bit_idx  <= 3'd0;
                            tm_stb   <= 1'b0;
                            state    <= STB_SETUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_led_tx.sv
// -----------------------------------------------------------------------------
// tb_tm1638_led_tx
// Directed bench for tm1638_led_tx (CLK_DIV=2, BRIGHTNESS=7). A bus monitor
// decodes every STB-low window into a frame record {bit count, byte1, byte0}
// and records the length of every busy pulse; the stimulus pushes the frames
// it expects into a scoreboard queue and compares after each transfer.
// -----------------------------------------------------------------------------
module tb_tm1638_led_tx;

    logic       clk = 1'b0;
    logic       rs  = 1'b1;
    logic [7:0] led = 8'h00;
    logic       tm_stb;
    logic       tm_clk;
    logic       tm_dio;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef TM_BLANK_DIGITS_EN
    localparam int EXP_BUSY = 1197;
`else
    localparam int EXP_BUSY = 637;
`endif

    tm1638_led_tx #(.CLK_DIV(2), .BRIGHTNESS(3'd7)) dut (
        .clk    (clk),
        .rs     (rs),
        .led    (led),
        .tm_stb (tm_stb),
        .tm_clk (tm_clk),
        .tm_dio (tm_dio),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];
    int          dur_q[$];

    // Bus monitor, sampled on the falling clk edge.
    logic        prev_stb  = 1'b1;
    logic        prev_clk  = 1'b1;
    logic        prev_busy = 1'b0;
    int          nbits     = 0;
    logic [15:0] acc       = '0;
    int          bcnt      = 0;

    always @(negedge clk) begin
        if (prev_stb && !tm_stb) begin
            nbits = 0;
            acc   = '0;
        end
        if (!tm_stb && !prev_clk && tm_clk) begin
            if (nbits < 16) acc[nbits] = tm_dio;
            nbits++;
        end
        if (!prev_stb && tm_stb) rx_q.push_back({16'(nbits), acc});
        if (busy) bcnt++;
        else if (prev_busy) begin
            dur_q.push_back(bcnt);
            bcnt = 0;
        end
        prev_stb  = tm_stb;
        prev_clk  = tm_clk;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame1(input logic [7:0] b);
        return {16'd8, 8'h00, b};
    endfunction

    function automatic logic [31:0] frame2(input logic [7:0] a, input logic [7:0] d);
        return {16'd16, d, a};
    endfunction

    task automatic push_transfer(input logic [7:0] v);
        exp_q.push_back(frame1(8'h44));
`ifdef TM_BLANK_DIGITS_EN
        for (int j = 0; j < 8; j++) exp_q.push_back(frame2(8'hC0 + 8'(2 * j), 8'h00));
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back(frame2(8'hC1 + 8'(2 * i), {7'b0, v[i]}));
        exp_q.push_back(frame1(8'h8F));
    endtask

    task automatic wait_busy(input logic v, input int max, input string tag);
        int k = 0;
        while (busy !== v && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, busy}, {31'b0, v});
    endtask

    task automatic compare_frames(input string tag);
        logic [31:0] got;
        logic [31:0] want;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            check({tag, "_frame"}, got, want);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_duration(input string tag);
        int d;
        if (dur_q.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            d = dur_q.pop_front();
            check(tag, (d >= EXP_BUSY - 2 && d <= EXP_BUSY + 2) ? EXP_BUSY : d, EXP_BUSY);
        end
    endtask

    initial begin
        int k;
        int bad;

        // Reset and init transfer.
        rs  = 1'b1;
        led = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_stb",  {31'b0, tm_stb}, 32'd1);
        check("rst_clk",  {31'b0, tm_clk}, 32'd1);
        check("rst_dio",  {31'b0, tm_dio}, 32'd1);
        check("rst_busy", {31'b0, busy},   32'd0);
        rx_q.delete();
        dur_q.delete();
        push_transfer(8'h00);
        rs = 1'b0;
        @(negedge clk);
        check("init_busy_rise", {31'b0, busy}, 32'd1);
        wait_busy(1'b0, 3000, "init_done");
        repeat (3) @(negedge clk);
        compare_frames("init");
        check_duration("init_busy_len");

        // Single change 0x00 -> 0x05.
        led = 8'h05;
        push_transfer(8'h05);
        wait_busy(1'b1, 3, "chg_start");
        wait_busy(1'b0, 3000, "chg_done");
        repeat (3) @(negedge clk);
        compare_frames("chg05");
        check_duration("chg05_busy_len");

        // Several changes during one transfer: one follow-up with latest value.
        led = 8'hFF;
        push_transfer(8'hFF);
        push_transfer(8'hA0);
        wait_busy(1'b1, 3, "multi_start");
        repeat (50) @(negedge clk);
        led = 8'h3C;
        repeat (50) @(negedge clk);
        led = 8'hA0;
        wait_busy(1'b0, 3000, "multi_done1");
        wait_busy(1'b1, 3, "multi_follow");
        wait_busy(1'b0, 3000, "multi_done2");
        repeat (3) @(negedge clk);
        compare_frames("multi");
        check_duration("multi_busy_len1");
        check_duration("multi_busy_len2");

        // Stable input: bus stays idle.
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tm_stb !== 1'b1 || tm_clk !== 1'b1 || tm_dio !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_violations", bad, 32'd0);
        check("idle_no_frames", rx_q.size(), 32'd0);

        // Reset during BIT_LOW of F4.
        led = 8'h5A;
        wait_busy(1'b1, 3, "abort_start");
        k = 0;
        while (rx_q.size() < 4 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_f4", rx_q.size(), 32'd4);
        k = 0;
        while (!(tm_clk === 1'b0 && tm_stb === 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_bit_low", {30'b0, tm_stb, tm_clk}, 32'd0);
        rs = 1'b1;
        @(posedge clk);
        #1;
        check("abort_stb",  {31'b0, tm_stb}, 32'd1);
        check("abort_clk",  {31'b0, tm_clk}, 32'd1);
        check("abort_dio",  {31'b0, tm_dio}, 32'd1);
        check("abort_busy", {31'b0, busy},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rx_q.delete();
        dur_q.delete();
        exp_q.delete();
        push_transfer(8'h5A);
        rs = 1'b0;
        wait_busy(1'b1, 3, "restart_start");
        wait_busy(1'b0, 3000, "restart_done");
        repeat (3) @(negedge clk);
        compare_frames("restart");
        check_duration("restart_busy_len");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
